sccb_responder: RTL

SCCB_RESPONDER -- requirements
Module: sccb_responder

---
 rtl/sccb_responder.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sccb_responder.sv
// ---------------------------------------------------------------------------
// sccb_responder
//
// Write-only SCCB (camera control bus) responder. It watches SIOC/SIOD,
// recognises START/STOP, and accepts 3-phase writes of the form
// ID, sub-address, data. It reports each completed write with a one-cycle
// strobe and keeps a saturating count of completed writes.
//
// The SIOC/SIOD inputs pass through SYNC_STAGES flops and one edge-detect
// register. An edge therefore takes effect SYNC_STAGES+1 clk after the
// line changes.
//
// Optional feature (macro SCCB_RESP_ACK_EN):
//   defined   - the responder pulls SIOD low through the 9th bit of every
//               accepted byte (ID match, ADDR, DATA).
//   undefined - siod_oe is tied low and the 9th bit is only counted.
//
// Parameters
//   DEVICE_ID   8-bit write ID this responder answers to (bit 0 = 0)
//   SYNC_STAGES synchronizer depth on sioc/siod, legal range 2..3
//
// Ports
//   clk       in   system clock, all logic on its rising edge
//   rst       in   synchronous active-high reset
//   sioc      in   SIOC line level (1 = released/high)
//   siod      in   SIOD line level (1 = released/high)
//   siod_oe   out  pulls SIOD low when 1 (open-drain)
//   wr_valid  out  one-cycle strobe for a completed 3-phase write
//   wr_addr   out  register sub-address of the last write (held)
//   wr_data   out  register data of the last write (held)
//   busy      out  1 from START until STOP or reset
//   id_err    out  one-cycle pulse when the ID byte is not DEVICE_ID
//   wr_count  out  completed writes, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module sccb_responder #(
    parameter logic [7:0] DEVICE_ID   = 8'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sioc,
    input  logic        siod,
    output logic        siod_oe,
    output logic        wr_valid,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        id_err,
    output logic [15:0] wr_count
);

    typedef enum logic [2:0] {
        IDLE,
        ID,
        ID_ACK,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] sioc_sync;
    logic [SYNC_STAGES-1:0] siod_sync;
    logic                   sioc_prev;
    logic                   siod_prev;
    logic                   sioc_s;
    logic                   siod_s;
    logic                   sioc_rise;
    logic                   sioc_fall;
    logic                   start_det;
    logic                   stop_det;

    state_t      state_q, state_n;
    logic [3:0]  bit_cnt_q, bit_cnt_n;
    logic [7:0]  shift_q, shift_n;
    logic [7:0]  addr_q, addr_n;
    logic [7:0]  byte_in;
    logic        wr_valid_n;
    logic        id_err_n;
    logic [7:0]  wr_addr_n;
    logic [7:0]  wr_data_n;
    logic [15:0] wr_count_n;

`ifdef SCCB_RESP_ACK_EN
    logic ack_q, ack_n;
`endif

    // Synchronizers reset to the idle bus level (both lines high).
    // Otherwise the first cycles after reset could look like a START.
    always_ff @(posedge clk) begin
        if (rst) begin
            sioc_sync <= '1;
            siod_sync <= '1;
            sioc_prev <= 1'b1;
            siod_prev <= 1'b1;
        end else begin
            sioc_sync <= {sioc_sync[SYNC_STAGES-2:0], sioc};
            siod_sync <= {siod_sync[SYNC_STAGES-2:0], siod};
            sioc_prev <= sioc_s;
            siod_prev <= siod_s;
        end
    end

    assign sioc_s    = sioc_sync[SYNC_STAGES-1];
    assign siod_s    = siod_sync[SYNC_STAGES-1];
    assign sioc_rise = sioc_s & ~sioc_prev;
    assign sioc_fall = ~sioc_s & sioc_prev;
    // SIOD may only change while SIOC is low. A SIOD edge while SIOC is
    // high is therefore a bus condition, not data.
    assign start_det = ~siod_s & siod_prev & sioc_s;
    assign stop_det  = siod_s & ~siod_prev & sioc_s;

    // The byte as it will look once the current bit is shifted in.
    assign byte_in = {shift_q[6:0], siod_s};

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'h00;
            addr_q    <= 8'h00;
            wr_valid  <= 1'b0;
            id_err    <= 1'b0;
            wr_addr   <= 8'h00;
            wr_data   <= 8'h00;
            wr_count  <= 16'h0000;
        end else begin
            state_q   <= state_n;
            bit_cnt_q <= bit_cnt_n;
            shift_q   <= shift_n;
            addr_q    <= addr_n;
            wr_valid  <= wr_valid_n;
            id_err    <= id_err_n;
            wr_addr   <= wr_addr_n;
            wr_data   <= wr_data_n;
            wr_count  <= wr_count_n;
        end
    end

    // Next-state logic. STOP and START take priority over byte handling in
    // every state. A START outside IDLE is a repeated start, and any
    // partial transaction is dropped.
    //
    // In the _ACK states the bit counter holds 8 until the 9th SIOC rise,
    // then 0. The SIOC fall that ends the 8th bit (count 8) is therefore
    // distinguished from the fall that ends the 9th bit (count 0). Only
    // the second one advances the state.
    always_comb begin
        state_n    = state_q;
        bit_cnt_n  = bit_cnt_q;
        shift_n    = shift_q;
        addr_n     = addr_q;
        wr_valid_n = 1'b0;
        id_err_n   = 1'b0;
        wr_addr_n  = wr_addr;
        wr_data_n  = wr_data;
        wr_count_n = wr_count;
`ifdef SCCB_RESP_ACK_EN
        ack_n      = ack_q;
`endif

        if (stop_det) begin
            state_n   = IDLE;
            bit_cnt_n = 4'd0;
`ifdef SCCB_RESP_ACK_EN
            ack_n     = 1'b0;
`endif
        end else if (start_det) begin
            state_n   = ID;
            bit_cnt_n = 4'd0;
`ifdef SCCB_RESP_ACK_EN
            ack_n     = 1'b0;
`endif
        end else begin
            case (state_q)
                ID, ADDR, DATA: begin
                    if (sioc_rise) begin
                        shift_n = byte_in;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_n = 4'd8;
                            case (state_q)
                                ID: begin
                                    if (byte_in != DEVICE_ID) begin
                                        id_err_n  = 1'b1;
                                        bit_cnt_n = 4'd0;
                                        state_n   = WAIT_STOP;
                                    end else begin
                                        state_n = ID_ACK;
                                    end
                                end
                                ADDR: begin
                                    addr_n  = byte_in;
                                    state_n = ADDR_ACK;
                                end
                                default: begin
                                    wr_valid_n = 1'b1;
                                    wr_addr_n  = addr_q;
                                    wr_data_n  = byte_in;
                                    if (wr_count != 16'hFFFF) begin
                                        wr_count_n = wr_count + 16'd1;
                                    end
                                    state_n = DATA_ACK;
                                end
                            endcase
                        end else begin
                            bit_cnt_n = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ID_ACK, ADDR_ACK, DATA_ACK: begin
                    if (sioc_rise && bit_cnt_q == 4'd8) begin
                        bit_cnt_n = 4'd0;
                    end else if (sioc_fall && bit_cnt_q == 4'd0) begin
                        case (state_q)
                            ID_ACK:   state_n = ADDR;
                            ADDR_ACK: state_n = DATA;
                            default:  state_n = WAIT_STOP;
                        endcase
                    end
`ifdef SCCB_RESP_ACK_EN
                    // Pull SIOD low from the fall that ends the 8th bit
                    // until the fall that ends the 9th bit.
                    if (sioc_fall) begin
                        ack_n = (bit_cnt_q == 4'd8);
                    end
`endif
                end
                default: begin
                    // IDLE and WAIT_STOP only react to START/STOP above.
                end
            endcase
        end
    end

`ifdef SCCB_RESP_ACK_EN
    // Acknowledge driver register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= ack_n;
        end
    end

    assign siod_oe = ack_q;
`else
    assign siod_oe = 1'b0;
`endif

    assign busy = (state_q != IDLE);

endmodule
